// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with baud divider, input FIFO and runtime parity/stop-bit selection
module uart_tx_cfg #(
    parameter int NB_DATA    = 8,
    parameter int BAUD_DIV   = 163,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_valid,
    input  logic [NB_DATA-1:0]                i_data,
    output logic                              o_ready,
    input  logic [1:0]                        i_parity_mode,
    input  logic                              i_two_stop,
    output logic                              o_tx,
    output logic                              o_busy,
    output logic                              o_tx_done_tick,
    output logic [$clog2(FIFO_DEPTH):0]       o_fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [NB_DATA-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [DW-1:0]        div_cnt;
    logic [4:0]           tick_cnt;
    logic [3:0]           bit_cnt;
    logic [NB_DATA-1:0]   shift;
    logic                 par_en, par_bit, two_stop;
    logic                 baud_tick, bit_end, stop_end, have_word, push, pop;

    assign have_word = count != '0;
    assign o_ready   = count != CW'(FIFO_DEPTH);
    assign push      = i_valid && o_ready;
    assign baud_tick = state != IDLE && div_cnt == DW'(BAUD_DIV - 1);
    assign bit_end   = baud_tick && tick_cnt[3:0] == 4'd15;
    assign stop_end  = baud_tick && tick_cnt == (two_stop ? 5'd31 : 5'd15);
    assign pop       = have_word && (state == IDLE || (state == STOP && stop_end));
    assign o_fifo_count = count;

    // FIFO storage; contents need no reset because the pointers and count define validity
    always_ff @(posedge i_clock) begin
        if (push) mem[wr_ptr] <= i_data;
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Oversample divider, parked at zero while idle so every bit has full length
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) div_cnt <= '0;
        else if (state == IDLE) div_cnt <= '0;
        else div_cnt <= div_cnt == DW'(BAUD_DIV - 1) ? '0 : div_cnt + DW'(1);
    end

    // Frame sequencer with registered line, busy and done outputs (one cycle behind the state)
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            shift          <= '0;
            par_en         <= 1'b0;
            par_bit        <= 1'b0;
            two_stop       <= 1'b0;
            o_tx           <= 1'b1;
            o_busy         <= 1'b0;
            o_tx_done_tick <= 1'b0;
        end else begin
            o_tx           <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par_bit : 1'b1;
            o_busy         <= state != IDLE;
            o_tx_done_tick <= state == STOP && stop_end;
            if (state == IDLE) tick_cnt <= '0;
            else if (baud_tick) tick_cnt <= (state == STOP ? stop_end : bit_end) ? '0 : tick_cnt + 5'd1;
            if (pop) begin
                shift    <= mem[rd_ptr];
                par_en   <= ^i_parity_mode;
                par_bit  <= ^mem[rd_ptr] ^ i_parity_mode[1];
                two_stop <= i_two_stop;
            end
            case (state)
                IDLE:   if (have_word) state <= START;
                START:  if (bit_end) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
                DATA:   if (bit_end) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'(NB_DATA - 1)) state <= par_en ? PARITY : STOP;
                end
                PARITY: if (bit_end) state <= STOP;
                STOP:   if (stop_end) state <= have_word ? START : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

- Parametrised UART transmitter with an integrated baud-tick divider and a small input FIFO.
- Accepts words over a valid/ready handshake and serialises them back-to-back, LSB first.
- Frame format is runtime-selectable: parity none/even/odd, 1 or 2 stop bits.
- Replaces the fixed 8N1 transmitter/baud-generator pair as the TX side of the UART subsystem.

## Interface
- NB_DATA, 8, data bits per frame (legal 5..9)
- BAUD_DIV, 163, clock cycles per oversample tick (legal ≥ 2); 16 ticks per bit
- FIFO_DEPTH, 4, input FIFO entries (power of 2, ≥ 2)
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  reset, asynchronous, active-high
- i_valid  in  1  producer presents i_data
- i_data  in  NB_DATA  word to send
- o_ready  out  1  FIFO not full; word accepted on an edge where i_valid & o_ready
- i_parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- i_two_stop  in  1  1 = two stop bits
- o_tx  out  1  serial line, idle high
- o_busy  out  1  frame in progress (state ≠ IDLE)
- o_tx_done_tick  out  1  one-cycle pulse at end of each frame's last stop bit
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  entries currently stored

## Operation
- Reset (asynchronous, immediate) values:
  - o_tx=1, o_busy=0, o_tx_done_tick=0, o_ready=1, o_fifo_count=0
  - FSM in IDLE; divider and all counters at 0; FIFO emptied.
- FIFO:
  - Circular buffer with read/write pointers plus a count.
  - Push on i_valid & o_ready; pop when the FSM starts a frame.
  - Simultaneous push and pop leaves the count unchanged.
  - Push while full is impossible (o_ready=0); pop while empty never occurs.
  - Pointers wrap modulo FIFO_DEPTH.
- Baud divider:
  - Counts 0..BAUD_DIV-1 and emits a 1-cycle tick at BAUD_DIV-1.
  - Held at 0 in IDLE, so every bit is exactly 16·BAUD_DIV cycles.
  - Keeps running across back-to-back frames.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop it, latch the word, i_parity_mode and i_two_stop, then go to START.
  - START (o_tx=0, 16 ticks) → DATA.
  - DATA: o_tx = shift[0]; shift right every 16 ticks; after NB_DATA bits go to PARITY if parity is enabled, else STOP.
  - PARITY (16 ticks): bit = XOR of the latched word (even), or its inverse (odd).
  - STOP (o_tx=1): 16 ticks, or 32 ticks with two stop bits. On the final tick, pulse o_tx_done_tick, then go to START with a pop if the FIFO is non-empty, else to IDLE.
- Config inputs are sampled only at frame start; changes mid-frame affect the next frame only.
- o_tx is registered; no combinational path from any input to o_tx.

## Timing
- Word accepted at edge k into an empty FIFO while IDLE:
  - Pop at edge k+1.
  - o_tx falls at edge k+2.
  - o_busy=1 from edge k+2.
- Frame length in bits = 1 + NB_DATA + P + S, where P is 1 with parity and 0 without, and S is 1 or 2.
- Frame length in cycles = 16·BAUD_DIV × frame length in bits.
- o_tx_done_tick is high for the single cycle ending the last stop bit.
- Back-to-back frames: the next start bit begins on the cycle after o_tx_done_tick; no idle gap.
- o_ready re-asserts the cycle after a pop frees a slot.
- o_fifo_count updates one edge after a push/pop.
- Reset asserted mid-frame:
  - o_tx returns high immediately.
  - No o_tx_done_tick.
  - Queued words are discarded.

## Test plan
All scenarios use BAUD_DIV=4, so 1 bit = 64 cycles.
- Reset then idle 1000 cycles:
  - o_tx=1, o_busy=0, o_ready=1, o_fifo_count=0 throughout.
  - No o_tx_done_tick.
- Send 0xA5, 8N1:
  - o_tx bits = 0, 1,0,1,0,0,1,0,1, 1, each exactly 64 cycles.
  - o_tx_done_tick pulses once, 640 cycles after o_tx falls.
  - o_tx falls 2 edges after acceptance.
- Parity and stop bits on 0x07:
  - Even parity: parity bit = 1.
  - Odd parity: parity bit = 0.
  - Even parity with i_two_stop=1: frame lasts 768 cycles.
- Hold i_valid high with 0x01..0x06, FIFO_DEPTH=4:
  - 0x01..0x05 accepted on consecutive edges; o_ready drops after 0x05.
  - 0x06 accepted the cycle after the second frame's pop.
  - Six frames sent contiguously, 3840 cycles total, data in order.
- Change i_parity_mode 00→01 during the DATA state of frame 1:
  - Frame 1 has no parity bit.
  - Frame 2 has the even parity bit.
- Assert i_reset during data bit 3 with 2 words queued:
  - o_tx=1 immediately; o_fifo_count=0; no o_tx_done_tick.
  - After release, one pushed 0x3C produces a clean 640-cycle frame.
